// File: rtl/icache_ctrl.sv
// Instruction-cache miss controller: hit reporting, one outstanding LOAD, block fill with bypass.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_ctrl #(
    parameter int TAG_W     = 22,
    parameter int IDX_W     = 7,
    parameter int MEM_TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          proc2Icache_addr,
    input  logic                 proc2Icache_req,
    output logic [63:0]          Icache_data_out,
    output logic                 Icache_valid_out,
    output logic [TAG_W-1:0]     current_tag,
    output logic [IDX_W-1:0]     current_index,
    input  logic [63:0]          cachemem_data,
    input  logic                 cachemem_valid,
    output logic                 wr1_en,
    output logic [TAG_W-1:0]     wr1_tag,
    output logic [IDX_W-1:0]     wr1_idx,
    output logic [63:0]          wr1_data,
    output logic [1:0]           proc2mem_command,
    output logic [31:0]          proc2mem_addr,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state;
    state_t               next_state;
    logic [TAG_W-1:0]     miss_tag;
    logic [IDX_W-1:0]     miss_idx;
    logic [MEM_TAG_W-1:0] pend_tag;

    logic addr_match;
    logic hit;
    logic bypass;
    logic start_miss;
    logic accept;
    logic fill;
    logic unused_addr_bits;

    assign current_tag      = proc2Icache_addr[31 -: TAG_W];
    assign current_index    = proc2Icache_addr[3 +: IDX_W];
    assign unused_addr_bits = ^proc2Icache_addr[2:0];

    assign addr_match = (current_tag == miss_tag) && (current_index == miss_idx);
    assign hit        = proc2Icache_req && cachemem_valid;

    always_comb begin
        next_state       = state;
        start_miss       = 1'b0;
        accept           = 1'b0;
        fill             = 1'b0;
        proc2mem_command = CMD_NONE;
        case (state)
            IDLE: begin
                if (proc2Icache_req && !cachemem_valid) begin
                    start_miss = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                proc2mem_command = CMD_LOAD;
                // An accepted LOAD must be tracked even if the fetch has moved on.
                if (mem2proc_response != '0) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end else if (!proc2Icache_req || !addr_match) begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if ((pend_tag != '0) && (mem2proc_tag == pend_tag)) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign proc2mem_addr    = {miss_tag, miss_idx, 3'b000};
    assign wr1_en           = fill;
    assign wr1_tag          = miss_tag;
    assign wr1_idx          = miss_idx;
    assign wr1_data         = mem2proc_data;
    assign bypass           = fill && proc2Icache_req && addr_match;
    assign Icache_valid_out = hit || bypass;
    assign Icache_data_out  = bypass ? mem2proc_data : cachemem_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            miss_tag <= '0;
            miss_idx <= '0;
            pend_tag <= '0;
        end else begin
            state <= next_state;
            if (start_miss) begin
                miss_tag <= current_tag;
                miss_idx <= current_index;
            end
            if (accept) begin
                pend_tag <= mem2proc_response;
            end else if (fill) begin
                pend_tag <= '0;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (Icache_valid_out) hit_count <= hit_count + 32'd1;
            if (start_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Instruction-cache miss controller between the fetch stage and the 128x64 direct-mapped cache memory. Splits the fetch address into tag/index, reports hits combinationally, and on a miss issues one LOAD to main memory, tracks the memory response tag, and writes the returned 64-bit block into the cache memory. Exactly one outstanding miss at a time.

## Interface
Parameters:
- TAG_W, 22, cache tag width (address bits [31:10])
- IDX_W, 7, cache index width (address bits [9:3])
- MEM_TAG_W, 4, memory transaction tag width; tag 0 means "not accepted"

Ports:
- clock  in  1  sole clock; all state on posedge
- reset  in  1  synchronous, active-high
- proc2Icache_addr  in  32  fetch address; bits [2:0] ignored
- proc2Icache_req  in  1  fetch request valid
- Icache_data_out  out  64  fetched block
- Icache_valid_out  out  1  Icache_data_out valid this cycle
- current_tag  out  TAG_W  proc2Icache_addr[31:10], to cache read tag
- current_index  out  IDX_W  proc2Icache_addr[9:3], to cache read index
- cachemem_data  in  64  cache read data
- cachemem_valid  in  1  cache read hit
- wr1_en  out  1  cache fill write enable
- wr1_tag  out  TAG_W  fill tag
- wr1_idx  out  IDX_W  fill index
- wr1_data  out  64  fill data
- proc2mem_command  out  2  0 = NONE, 1 = LOAD (2, 3 never driven)
- proc2mem_addr  out  32  {miss_tag, miss_idx, 3'b000}
- mem2proc_response  in  MEM_TAG_W  nonzero = LOAD accepted with this tag
- mem2proc_data  in  64  returned block
- mem2proc_tag  in  MEM_TAG_W  tag of returned block; 0 = nothing returning

## Operation
- Registered state: fsm (IDLE, REQ, WAIT), miss_tag, miss_idx, pend_tag (MEM_TAG_W).
- Hit: proc2Icache_req && cachemem_valid -> Icache_valid_out = 1, Icache_data_out = cachemem_data.
- IDLE: proc2Icache_req && !cachemem_valid -> latch miss_tag/miss_idx from current address, go REQ.
- REQ: proc2mem_command = LOAD, proc2mem_addr from miss_tag/miss_idx. At edge:
  - address tag/index differs from miss_tag/miss_idx or req low -> abandon, IDLE (command already issued this cycle with nonzero response takes priority: go WAIT).
  - mem2proc_response != 0 -> pend_tag <= response, WAIT.
  - else stay REQ (retry LOAD).
- WAIT: proc2mem_command = NONE. When mem2proc_tag == pend_tag (pend_tag nonzero): wr1_en = 1, wr1_tag = miss_tag, wr1_idx = miss_idx, wr1_data = mem2proc_data; go IDLE; pend_tag <= 0. Fill always completes even if fetch address has moved.
- Bypass: in the fill cycle, if req and current tag/index equal miss_tag/miss_idx, Icache_valid_out = 1 with Icache_data_out = mem2proc_data.
- New misses in REQ/WAIT are not started; Icache_valid_out = 0 unless hit or bypass.
- mem2proc_tag of 0 never matches.

## Timing
- Hit: zero-cycle, combinational from address.
- Miss: miss seen cycle N; LOAD on proc2mem_command from cycle N+1 until accepted (inclusive).
- Fill cycle F: wr1_en high exactly one cycle; bypass valid in F; cache hit from F+1.
- Minimum miss-to-data: 2 cycles plus memory latency.
- Reset (any state, mid-miss included): fsm = IDLE, miss_tag = 0, miss_idx = 0, pend_tag = 0; next cycle proc2mem_command = 0, wr1_en = 0, Icache_valid_out = 0 while reset high. A late memory return after reset is ignored.
- Outputs wr1_*, proc2mem_* are combinational from state; no output registers.

## Configuration
- ICACHE_STATS_EN defined: adds outputs hit_count and miss_count (32 bits each, out). hit_count +1 each cycle Icache_valid_out is high (bypass included); miss_count +1 on each IDLE->REQ transition. Both wrap modulo 2^32, clear to 0 on reset.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset then req addr 0x0000_0408 with cachemem_valid = 0 -> next cycle proc2mem_command = 1, proc2mem_addr = 0x0000_0408; response 3 -> WAIT; mem2proc_tag = 3, data 0xDEAD_BEEF_0123_4567 -> wr1_en = 1, wr1_idx = 0x01, wr1_tag = 0x000001, Icache_valid_out = 1 same cycle.
- Response 0 for 4 cycles then 5 -> LOAD held 5 cycles with constant address, WAIT entered after the fifth.
- In WAIT, mem2proc_tag = 2 (pend 5) -> no write; then 5 -> single-cycle fill.
- Address changes in REQ before acceptance -> IDLE, no fill; address changes in WAIT -> fill still written to original idx/tag, Icache_valid_out = 0 in fill cycle.
- Reset asserted in WAIT, then mem2proc_tag = old pend tag -> wr1_en stays 0.
- ICACHE_STATS_EN: 3 hits, 1 miss with bypass -> hit_count = 4, miss_count = 1.
